// File: rtl/reg_xfer_ctrl.sv
// reg_xfer_ctrl -- sequences register-to-register moves on a shared tri-state bus.
// Arbitrates among NUM_REQ requesters and drives per-register CS/OE/WE strobes.
// A valid move takes SETUP (source drives the bus) then LATCH (destination writes).
// An invalid request (src==dst or an index out of range) gets a one-cycle err pulse.
// Build option: define RR_ARB_EN for round-robin arbitration; otherwise the
// lowest-index active requester wins and no pointer register exists.
module reg_xfer_ctrl #(
  parameter int NUM_REGS = 4,
  parameter int NUM_REQ  = 4,
  localparam int SEL_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*SEL_W-1:0] src_sel,
  input  logic [NUM_REQ*SEL_W-1:0] dst_sel,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [NUM_REGS-1:0]      reg_cs,
  output logic [NUM_REGS-1:0]      reg_oe,
  output logic [NUM_REGS-1:0]      reg_we
);

  localparam int REQ_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0]  ONE_REQ = {{(NUM_REQ-1){1'b0}}, 1'b1};
  localparam logic [NUM_REGS-1:0] ONE_REG = {{(NUM_REGS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ERR   = 2'd1,
    ST_SETUP = 2'd2,
    ST_LATCH = 2'd3
  } state_t;

  state_t              r_state;
  logic [NUM_REQ-1:0]  r_grant;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic [NUM_REGS-1:0] r_cs;
  logic [NUM_REGS-1:0] r_oe;
  logic [NUM_REGS-1:0] r_we;
  logic [SEL_W-1:0]    r_dst;

  logic             w_any;
  logic [REQ_W-1:0] w_win;
  logic [SEL_W-1:0] w_src;
  logic [SEL_W-1:0] w_dst;
  logic             w_valid;

`ifdef RR_ARB_EN
  logic [REQ_W-1:0] r_rr_ptr;

  // Round-robin pick: first active request at or after the pointer, wrapping.
  always_comb begin
    int j;
    // NOTE: every variable gets a default before any condition so no latch is inferred.
    w_any = 1'b0;
    w_win = '0;
    j     = 0;
    // Walk from the far end so the nearest hit to the pointer is assigned last.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(r_rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (req[j[REQ_W-1:0]]) begin
        w_any = 1'b1;
        w_win = j[REQ_W-1:0];
      end
    end
  end

  // Pointer moves past the winner after every grant, valid or rejected.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr <= '0;
    end else if (r_state == ST_IDLE && w_any) begin
      if (int'(w_win) == NUM_REQ - 1) r_rr_ptr <= '0;
      else                            r_rr_ptr <= w_win + REQ_W'(1);
    end
  end
`else
  // Fixed priority pick: lowest-index active request wins.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        w_any = 1'b1;
        w_win = REQ_W'(i);
      end
    end
  end
`endif

  // Winner's indices, and whether the move it asks for is legal.
  assign w_src   = src_sel[w_win*SEL_W +: SEL_W];
  assign w_dst   = dst_sel[w_win*SEL_W +: SEL_W];
  assign w_valid = (w_src != w_dst) &&
                   (int'(w_src) < NUM_REGS) && (int'(w_dst) < NUM_REGS);

  // Transfer sequencer; every output is produced here as a register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_cs    <= '0;
      r_oe    <= '0;
      r_we    <= '0;
      r_dst   <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_grant <= ONE_REQ << w_win;
            r_dst   <= w_dst;
            if (w_valid) begin
              r_state <= ST_SETUP;
              r_busy  <= 1'b1;
              r_cs    <= ONE_REG << w_src;
              r_oe    <= ONE_REG << w_src;
            end else begin
              r_state <= ST_ERR;
              r_err   <= 1'b1;
            end
          end
        end
        ST_ERR: begin
          r_state <= ST_IDLE;
          r_grant <= '0;
        end
        ST_SETUP: begin
          // Source keeps driving; destination is selected and written at the closing edge.
          r_state <= ST_LATCH;
          r_done  <= 1'b1;
          r_cs    <= r_cs | (ONE_REG << r_dst);
          r_we    <= ONE_REG << r_dst;
        end
        ST_LATCH: begin
          r_state <= ST_IDLE;
          r_grant <= '0;
          r_busy  <= 1'b0;
          r_cs    <= '0;
          r_oe    <= '0;
          r_we    <= '0;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign grant  = r_grant;
  assign busy   = r_busy;
  assign done   = r_done;
  assign err    = r_err;
  assign reg_cs = r_cs;
  assign reg_oe = r_oe;
  assign reg_we = r_we;

endmodule
